// File: rtl/flu_hdr_fifo_pkg.sv
// Shared types and helpers for the FLU header source buffer.
// The header entry is one header word plus its length (last valid byte index).
package flu_hdr_pkg;

    localparam int unsigned HDR_WIDTH     = 512;
    localparam int unsigned HDR_POS_WIDTH = 6;
    localparam int unsigned HDR_DEPTH     = 16;

    typedef struct packed {
        logic [HDR_WIDTH-1:0]     data;
        logic [HDR_POS_WIDTH-1:0] len;
    } hdr_entry_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/flu_hdr_fifo_if.sv
// Header input (valid/ready) and FLU HDR output bundle of the header buffer.
// slave: the buffer itself; master: producer and header-insert side.
interface flu_hdr_fifo_if;
    import flu_hdr_pkg::*;

    logic [HDR_WIDTH-1:0]     HDR_IN_DATA;
    logic [HDR_POS_WIDTH-1:0] HDR_IN_LEN;
    logic                     HDR_IN_SRC_RDY;
    logic                     HDR_IN_DST_RDY;

    logic [HDR_WIDTH-1:0]     HDR_DATA;
    logic                     HDR_SOP_POS;
    logic [HDR_POS_WIDTH-1:0] HDR_EOP_POS;
    logic                     HDR_SOP;
    logic                     HDR_EOP;
    logic                     HDR_SRC_RDY;
    logic                     HDR_DST_RDY;

    modport slave (
        input  HDR_IN_DATA, HDR_IN_LEN, HDR_IN_SRC_RDY, HDR_DST_RDY,
        output HDR_IN_DST_RDY, HDR_DATA, HDR_SOP_POS, HDR_EOP_POS,
               HDR_SOP, HDR_EOP, HDR_SRC_RDY
    );

    modport master (
        output HDR_IN_DATA, HDR_IN_LEN, HDR_IN_SRC_RDY, HDR_DST_RDY,
        input  HDR_IN_DST_RDY, HDR_DATA, HDR_SOP_POS, HDR_EOP_POS,
               HDR_SOP, HDR_EOP, HDR_SRC_RDY
    );

endinterface

// File: rtl/flu_hdr_fifo_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read data is held in its own register and only changes when re_i is set.
module flu_hdr_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned W     = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Array write and registered read; no reset on storage.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/flu_hdr_fifo.sv
// FLU header source buffer: stores one header per packet and presents each as
// a single-word FLU frame (SOP=EOP, SOP_POS=0, EOP_POS=len).
// Optional feature macro FLU_HDR_FIFO_DROP_EN: input always ready, writes
// arriving while full are discarded and counted in DROP_CNT.
// rd_ptr only advances when header-insert consumes a word, so the entries in
// the RAM read stage and the output register still count as occupied.
// fe_ptr is the RAM fetch address running ahead of rd_ptr.
module flu_hdr_fifo
    import flu_hdr_pkg::*;
#(
    parameter int unsigned DEPTH = HDR_DEPTH
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    flu_hdr_fifo_if.slave           hdr,
    output logic [ptr_w(DEPTH)-1:0] OCCUPANCY,
    output logic [31:0]             DROP_CNT
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_VALID} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fe_ptr_q, fe_ptr_d;
    logic          s1_vld_q, s1_vld_d;
    logic          in_rdy_q, in_rdy_d;
    hdr_entry_t    out_q, out_d, wr_ent, ram_rdata;
    logic          full, wr_en, consume, out_ld, fe_en;

    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign consume = (state_q == ST_VALID) && hdr.HDR_DST_RDY;
    assign wr_ent  = '{data: hdr.HDR_IN_DATA, len: hdr.HDR_IN_LEN};

`ifdef FLU_HDR_FIFO_DROP_EN
    logic        drop;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    assign wr_en = hdr.HDR_IN_SRC_RDY && in_rdy_q && !full;
    assign drop  = hdr.HDR_IN_SRC_RDY && in_rdy_q && full;

    // Saturating count of headers discarded while full.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
    end

    // Drop counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign DROP_CNT = drop_cnt_q;
`else
    assign wr_en    = hdr.HDR_IN_SRC_RDY && in_rdy_q;
    assign DROP_CNT = '0;
`endif

    flu_hdr_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     ($bits(hdr_entry_t))
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_ent),
        .re_i    (fe_en),
        .raddr_i (fe_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Next state: pointers, RAM fetch stage, prefetch FSM and output register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fe_ptr_d = fe_ptr_q;
        state_d  = state_q;
        // RAM stage moves to the output when the output is free or being read.
        out_ld   = s1_vld_q && ((state_q != ST_VALID) || consume);
        // Fetch when unread entries remain and the RAM stage will be free.
        fe_en    = (fe_ptr_q != wr_ptr_q) && (!s1_vld_q || out_ld);
        s1_vld_d = fe_en || (s1_vld_q && !out_ld);
        out_d    = out_ld ? ram_rdata : out_q;

        if (wr_en)   wr_ptr_d = wr_ptr_q + PW'(1);
        if (consume) rd_ptr_d = rd_ptr_q + PW'(1);
        if (fe_en)   fe_ptr_d = fe_ptr_q + PW'(1);

        unique case (state_q)
            ST_EMPTY:   if (fe_en) state_d = ST_LOADING;
            ST_LOADING: if (out_ld) state_d = ST_VALID;
            ST_VALID:   if (consume && !out_ld) state_d = fe_en ? ST_LOADING : ST_EMPTY;
            default:    state_d = ST_EMPTY;
        endcase

`ifdef FLU_HDR_FIFO_DROP_EN
        in_rdy_d = 1'b1;
`else
        // Ready for the next cycle reflects fullness after this cycle's traffic.
        in_rdy_d = !((wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
`endif
    end

    // State registers; reset drops every stored entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fe_ptr_q <= '0;
            state_q  <= ST_EMPTY;
            s1_vld_q <= 1'b0;
            in_rdy_q <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fe_ptr_q <= fe_ptr_d;
            state_q  <= state_d;
            s1_vld_q <= s1_vld_d;
            in_rdy_q <= in_rdy_d;
            out_q    <= out_d;
        end
    end

    assign hdr.HDR_IN_DST_RDY = in_rdy_q;
    assign hdr.HDR_DATA       = out_q.data;
    assign hdr.HDR_EOP_POS    = out_q.len;
    assign hdr.HDR_SOP_POS    = 1'b0;
    assign hdr.HDR_SRC_RDY    = (state_q == ST_VALID);
    assign hdr.HDR_SOP        = (state_q == ST_VALID);
    assign hdr.HDR_EOP        = (state_q == ST_VALID);
    assign OCCUPANCY          = wr_ptr_q - rd_ptr_q;

endmodule
